// File: rtl/ex_mdu.sv
// RV32M-style multiply/divide unit: iterative restoring divider and shift-add
// multiplier sharing one 2*XLEN accumulator, with a fast path for trivial cases.
//
// state | meaning
// IDLE  | waiting for start_i; special cases go straight to DONE
// CALC  | XLEN iterations, one quotient/product bit per cycle
// FIX   | sign correction and result select
// DONE  | one-cycle writeback strobe
module ex_mdu #(
    parameter int XLEN     = 32,
    parameter int MUL_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic              s1_q;
    logic              s2_q;
    logic [CW-1:0]     cnt_q;
    logic              wen_q;

    // operand decode for the incoming request
    logic            is_div;
    logic            sgn1;
    logic            sgn2;
    logic            neg1;
    logic            neg2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            div_ovf;
    logic            mul_fast;
    logic            bypass;
    logic [XLEN-1:0] bypass_res;
    logic [2*XLEN-1:0] fast_prod;

    assign is_div   = op_i[2];
    assign sgn1     = is_div ? ~op_i[0] : ~(op_i[1] & op_i[0]);
    assign sgn2     = is_div ? ~op_i[0] : ~op_i[1];
    assign neg1     = sgn1 & op1_i[XLEN-1];
    assign neg2     = sgn2 & op2_i[XLEN-1];
    assign abs1     = neg1 ? -op1_i : op1_i;
    assign abs2     = neg2 ? -op2_i : op2_i;
    assign div_zero = is_div & (op2_i == '0);
    assign div_ovf  = is_div & ~op_i[0] & (op1_i == MOST_NEG) & (op2_i == '1);
    assign mul_fast = (MUL_MODE == 1) & ~is_div;
    assign bypass   = div_zero | div_ovf | mul_fast;

    generate
        if (MUL_MODE == 1) begin : g_fast_mul
            logic [2*XLEN-1:0] fa;
            logic [2*XLEN-1:0] fb;
            assign fa        = {{XLEN{neg1}}, op1_i};
            assign fb        = {{XLEN{neg2}}, op2_i};
            assign fast_prod = fa * fb;
        end else begin : g_no_fast_mul
            assign fast_prod = '0;
        end
    endgenerate

    always_comb begin
        bypass_res = '0;
        if (div_zero) begin
            bypass_res = op_i[1] ? op1_i : '1;
        end else if (div_ovf) begin
            bypass_res = op_i[1] ? '0 : op1_i;
        end else if (op_i[1:0] == 2'b00) begin
            bypass_res = fast_prod[XLEN-1:0];
        end else begin
            bypass_res = fast_prod[2*XLEN-1:XLEN];
        end
    end

    // one iteration of each datapath; acc holds {remainder, quotient} or the running product
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] div_nxt;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mul_nxt;

    always_comb begin
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, opb_q};
        div_nxt = {acc_q[2*XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt = {sum, acc_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_fix = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:         fix_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_res = (s1_q ^ s2_q) ? -quo : quo;
            3'b110, 3'b111: fix_res = s1_q ? -rem : rem;
            default:        fix_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else if (flush_i) begin
            state     <= S_IDLE;
            wen_q     <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            wen_q     <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        rd_q  <= rd_addr_i;
                        s1_q  <= neg1;
                        s2_q  <= neg2;
                        cnt_q <= '0;
                        // divider keeps the dividend in acc; multiplier keeps the multiplier there
                        acc_q <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
                        opb_q <= is_div ? abs2 : abs1;
                        if (bypass) begin
                            state     <= S_DONE;
                            wen_q     <= 1'b1;
                            rd_addr_o <= rd_addr_i;
                            rd_data_o <= bypass_res;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_nxt : mul_nxt;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state     <= S_DONE;
                    wen_q     <= 1'b1;
                    rd_addr_o <= rd_q;
                    rd_data_o <= fix_res;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // a kill arriving in the writeback cycle still suppresses the strobe
    assign rd_wen_o    = wen_q & ~flush_i;
    assign hold_flag_o = rst_n & (((state == S_IDLE) & start_i) |
                                  (state == S_CALC) | (state == S_FIX));

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: iterative (XLEN=32), fast-multiply (XLEN=32) and
// narrow (XLEN=8) instances, with an 8-bit reference model for random ops.
module tb_ex_mdu;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    logic        start_a, start_b, start_c;
    logic [2:0]  op_a, op_b, op_c;
    logic [31:0] op1_a, op2_a, op1_b, op2_b;
    logic [7:0]  op1_c, op2_c;
    logic [4:0]  rd_a, rd_b, rd_c;
    logic        hold_a, hold_b, hold_c;
    logic        wen_a, wen_b, wen_c;
    logic [4:0]  addr_a, addr_b, addr_c;
    logic [31:0] data_a, data_b;
    logic [7:0]  data_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(32), .MUL_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .op_i(op_a), .op1_i(op1_a),
        .op2_i(op2_a), .rd_addr_i(rd_a), .flush_i(flush), .hold_flag_o(hold_a),
        .rd_addr_o(addr_a), .rd_data_o(data_a), .rd_wen_o(wen_a));

    ex_mdu #(.XLEN(32), .MUL_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .op_i(op_b), .op1_i(op1_b),
        .op2_i(op2_b), .rd_addr_i(rd_b), .flush_i(flush), .hold_flag_o(hold_b),
        .rd_addr_o(addr_b), .rd_data_o(data_b), .rd_wen_o(wen_b));

    ex_mdu #(.XLEN(8), .MUL_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .op_i(op_c), .op1_i(op1_c),
        .op2_i(op2_c), .rd_addr_i(rd_c), .flush_i(flush), .hold_flag_o(hold_c),
        .rd_addr_o(addr_c), .rd_data_o(data_c), .rd_wen_o(wen_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        case (sel)
            0: begin start_a = s; op_a = op; op1_a = a; op2_a = b; rd_a = rd; end
            1: begin start_b = s; op_b = op; op1_b = a; op2_b = b; rd_b = rd; end
            default: begin start_c = s; op_c = op; op1_c = a[7:0]; op2_c = b[7:0]; rd_c = rd; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic w, output logic h,
                           output logic [4:0] ad, output logic [31:0] d);
        case (sel)
            0: begin w = wen_a; h = hold_a; ad = addr_a; d = data_a; end
            1: begin w = wen_b; h = hold_b; ad = addr_b; d = data_b; end
            default: begin w = wen_c; h = hold_c; ad = addr_c; d = {24'h0, data_c}; end
        endcase
    endtask

    // Issue one op and follow it to writeback; lat counts cycles after the accepting edge.
    task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat, input string tag);
        int n;
        logic bad;
        logic w, h;
        logic [4:0] ad;
        logic [31:0] d;
        @(negedge clk);
        drive(sel, 1'b1, op, a, b, rd);
        #1;
        get_out(sel, w, h, ad, d);
        check({tag, "_hold_req"}, {31'b0, h}, 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        n = 1;
        bad = 1'b0;
        get_out(sel, w, h, ad, d);
        while (!w && n < 60) begin
            if (!h || d != 32'h0 || ad != 5'd0) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
            get_out(sel, w, h, ad, d);
        end
        check({tag, "_wen"}, {31'b0, w}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_addr"}, {27'b0, ad}, {27'b0, rd});
        check({tag, "_data"}, d, exp);
        check({tag, "_hold_done"}, {31'b0, h}, 32'd0);
        check({tag, "_busy_outputs"}, {31'b0, bad}, 32'd0);
        @(posedge clk);
        #1;
        get_out(sel, w, h, ad, d);
        check({tag, "_after_done"}, {w, d[30:0]}, 32'd0);
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ua, ub, p;
        sa = {{24{a[7]}}, a};
        sb = {{24{b[7]}}, b};
        ua = {24'h0, a};
        ub = {24'h0, b};
        p = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[7:0]; end
            3'd1: begin p = sa * sb; return p[15:8]; end
            3'd2: begin p = sa * ub; return p[15:8]; end
            3'd3: begin p = ua * ub; return p[15:8]; end
            3'd4: begin
                if (b == 8'h00) return 8'hFF;
                if (a == 8'h80 && b == 8'hFF) return 8'h80;
                p = sa / sb; return p[7:0];
            end
            3'd5: begin
                if (b == 8'h00) return 8'hFF;
                p = ua / ub; return p[7:0];
            end
            3'd6: begin
                if (b == 8'h00) return a;
                if (a == 8'h80 && b == 8'hFF) return 8'h00;
                p = sa % sb; return p[7:0];
            end
            default: begin
                if (b == 8'h00) return a;
                p = ua % ub; return p[7:0];
            end
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] rop;
        int lat;
        logic seen;
        rst_n = 1'b0;
        flush = 1'b0;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        drive(2, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        #23;
        start_a = 1'b1;
        #1;
        check("rst_hold_gated", {31'b0, hold_a}, 32'd0);
        check("rst_wen", {29'b0, wen_a, wen_b, wen_c}, 32'd0);
        check("rst_data", data_a | data_b, 32'd0);
        check("rst_addr", {17'b0, addr_a, addr_b, addr_c}, 32'd0);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2,       5'd5,  32'hFFFFFFFD, 34, "div_m7_2");
        run_op(0, 3'b110, 32'hFFFFFFF9, 32'd2,       5'd6,  32'hFFFFFFFF, 34, "rem_m7_2");
        run_op(0, 3'b111, 32'hFFFFFFF9, 32'd2,       5'd7,  32'd1,        34, "remu");
        run_op(0, 3'b101, 32'd100,      32'd7,       5'd0,  32'd14,       34, "divu_rd0");
        run_op(0, 3'b100, 32'd20,       32'hFFFFFFFD, 5'd3, 32'hFFFFFFFA, 34, "div_20_m3");
        run_op(0, 3'b110, 32'hFFFFFFEC, 32'd3,       5'd4,  32'hFFFFFFFE, 34, "rem_m20_3");
        run_op(0, 3'b101, 32'd5,        32'd0,       5'd8,  32'hFFFFFFFF, 1,  "divu_by0");
        run_op(0, 3'b110, 32'd5,        32'd0,       5'd9,  32'd5,        1,  "rem_by0");
        run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1, "div_ovf");
        run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,       1,  "rem_ovf");
        run_op(0, 3'b001, 32'h80000000, 32'h80000000, 5'd12, 32'h40000000, 34, "mulh_it");
        run_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF, 34, "mulhsu_it");
        run_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFE, 34, "mulhu_it");
        run_op(0, 3'b000, 32'd3,        32'hFFFFFFFC, 5'd15, 32'hFFFFFFF4, 34, "mul_it");

        run_op(1, 3'b001, 32'h80000000, 32'h80000000, 5'd16, 32'h40000000, 1, "mulh_fast");
        run_op(1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF, 1, "mulhsu_fast");
        run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd18, 32'hFFFFFFFE, 1, "mulhu_fast");
        run_op(1, 3'b000, 32'd3,        32'hFFFFFFFC, 5'd19, 32'hFFFFFFF4, 1, "mul_fast");
        run_op(1, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd20, 32'hFFFFFFFD, 34, "div_on_fast");

        // flush in CALC cycle 10, then an immediate new request
        @(negedge clk);
        drive(0, 1'b1, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd5);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle_hold", {31'b0, hold_a}, 32'd0);
        check("flush_no_wen", {31'b0, wen_a}, 32'd0);
        run_op(0, 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 34, "after_flush");

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        drive(0, 1'b1, 3'b101, 32'd100, 32'd7, 5'd22);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
        repeat (5) @(posedge clk);
        #2;
        check("calc_busy", {31'b0, hold_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_hold", {31'b0, hold_a}, 32'd0);
        check("midrst_outs", {wen_a, addr_a, data_a[25:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (wen_a || hold_a) seen = 1'b1;
        end
        check("midrst_no_wb", {31'b0, seen}, 32'd0);

        run_op(2, 3'b100, 32'h80, 32'hFF, 5'd1, 32'h80, 1, "div8_ovf");
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 3'(i % 8);
            if (i % 6 == 5) rb = 8'h00;
            lat = (rop[2] && (rb == 8'h00 || (!rop[0] && ra == 8'h80 && rb == 8'hFF))) ? 1 : 10;
            run_op(2, rop, {24'h0, ra}, {24'h0, rb}, 5'(i + 1), {24'h0, ref8(rop, ra, rb)},
                   lat, $sformatf("rnd8_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
